eth_mac_stats_collector: RTL

// Multi-channel statistics block for the MAC+FIFO wrappers. Counts single-cycle

---
 rtl/eth_mac_stats_collector_pkg.sv | 22 ++
 rtl/eth_stats_counter.sv | 47 ++++
 rtl/eth_mac_stats_collector.sv | 93 +++++++++
 3 files changed

// File: rtl/eth_mac_stats_collector_pkg.sv
// Shared definitions for the MAC statistics collector: event indices within a
// channel and the flat counter-index helper used by CSR software and benches.
package eth_mac_stats_collector_pkg;

  localparam int EV_TX_UNDERFLOW = 0;
  localparam int EV_TX_FIFO_OVF  = 1;
  localparam int EV_TX_FIFO_BAD  = 2;
  localparam int EV_TX_FIFO_GOOD = 3;
  localparam int EV_RX_BAD_FRAME = 4;
  localparam int EV_RX_BAD_FCS   = 5;
  localparam int EV_RX_FIFO_OVF  = 6;
  localparam int EV_RX_FIFO_BAD  = 7;
  localparam int EV_RX_FIFO_GOOD = 8;

  localparam int DEFAULT_EVENTS  = 9;

  // Counter index as seen on event_in and rd_addr: channel-major.
  function automatic int ev_flat_index(input int ch, input int ev, input int events);
    return ch * events + ev;
  endfunction

endpackage

// File: rtl/eth_stats_counter.sv
// One live statistics counter with a sticky overflow flag. A clear loads the
// coincident increment so an event landing on a clearing snapshot is kept.
module eth_stats_counter #(
  parameter int COUNT_WIDTH = 32,
  parameter int SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_inc,
  input  logic                   i_clear,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_sticky
);

  localparam logic [COUNT_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [COUNT_WIDTH-1:0] ONE      = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_sticky;
  logic                   w_at_max;

  assign w_at_max = (r_count == ALL_ONES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else if (i_clear) begin
      r_count  <= COUNT_WIDTH'(i_inc);
      r_sticky <= 1'b0;
    end else if (i_inc) begin
      if (w_at_max) begin
        // Holding at all-ones or wrapping both mean the count is no longer exact.
        r_sticky <= 1'b1;
        if (SATURATE == 0) begin
          r_count <= '0;
        end
      end else begin
        r_count <= r_count + ONE;
      end
    end
  end

  assign o_count  = r_count;
  assign o_sticky = r_sticky;

endmodule

// File: rtl/eth_mac_stats_collector.sv
// Multi-channel MAC status-event counters with atomic snapshot into a shadow
// bank and a registered, one-cycle-latency read port for the CSR bridge.
module eth_mac_stats_collector
  import eth_mac_stats_collector_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int EVENTS      = DEFAULT_EVENTS,
  parameter  int COUNT_WIDTH = 32,
  parameter  int SATURATE    = 1,
  localparam int N_CNT       = CHANNELS * EVENTS,
  localparam int ADDR_WIDTH  = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CNT-1:0]       event_in,
  input  logic                   snapshot_req,
  input  logic                   clear_on_snap,
  output logic                   snapshot_done,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic                   rd_sat,
  output logic                   rd_valid
);

  logic [COUNT_WIDTH-1:0] w_live [N_CNT];
  logic [N_CNT-1:0]       w_live_sat;
  logic                   w_clear;
  logic                   w_addr_ok;

  logic [COUNT_WIDTH-1:0] r_shadow [N_CNT];
  logic [N_CNT-1:0]       r_shadow_sat;
  logic                   r_snap_done;
  logic [COUNT_WIDTH-1:0] r_rd_data;
  logic                   r_rd_sat;
  logic                   r_rd_valid;

  assign w_clear   = snapshot_req & clear_on_snap;
  assign w_addr_ok = (int'(rd_addr) < N_CNT);

  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
    eth_stats_counter #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .SATURATE    (SATURATE)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_inc    (event_in[gi]),
      .i_clear  (w_clear),
      .o_count  (w_live[gi]),
      .o_sticky (w_live_sat[gi])
    );
  end

  // The shadow captures the live registers before this cycle's increments land,
  // and a same-cycle read sees the old shadow because both are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) begin
        r_shadow[i] <= '0;
      end
      r_shadow_sat <= '0;
      r_snap_done  <= 1'b0;
      r_rd_data    <= '0;
      r_rd_sat     <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_snap_done <= snapshot_req;
      r_rd_valid  <= rd_en;
      if (snapshot_req) begin
        for (int i = 0; i < N_CNT; i++) begin
          r_shadow[i] <= w_live[i];
        end
        r_shadow_sat <= w_live_sat;
      end
      if (rd_en) begin
        if (w_addr_ok) begin
          r_rd_data <= r_shadow[rd_addr];
          r_rd_sat  <= r_shadow_sat[rd_addr];
        end else begin
          r_rd_data <= '0;
          r_rd_sat  <= 1'b0;
        end
      end
    end
  end

  assign snapshot_done = r_snap_done;
  assign rd_data       = r_rd_data;
  assign rd_sat        = r_rd_sat;
  assign rd_valid      = r_rd_valid;

endmodule
